vga_addr_split: RTL

Sequential address decoder for the 200x150 framebuffer. It converts a 16-bit linear framebuffer address `eff` back into pixel coordinates (`posx`, `posy`), where `eff = posy*WIDTH + posx`. It is the inverse of the coordinate-to-address adder used on the write side, and it sits on the framebuffer read and scan path, where addresses must be turned back into screen positions for collision and draw logic. Division by WIDTH uses an iterative restoring shift-subtract with a start/valid handshake.

---
 rtl/vga_addr_split.sv | 102 ++++++++++
 1 files changed

// File: rtl/vga_addr_split.sv
// Converts a linear framebuffer address back into (x, y) pixel coordinates.
// Division by WIDTH is an 8-step restoring shift-subtract behind a start/valid handshake.
module vga_addr_split #(
  parameter int unsigned WIDTH  = 200,
  parameter int unsigned HEIGHT = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] eff,
  output logic        busy,
  output logic        valid,
  output logic [8:0]  posx,
  output logic [8:0]  posy,
  output logic        err
);

  localparam int unsigned RW = 17;
  localparam logic [RW-1:0] LIMIT   = RW'(WIDTH * HEIGHT);
  localparam logic [RW-1:0] DIVISOR = RW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_rem;
  logic [7:0]    r_q;
  logic [2:0]    r_k;
  logic          r_oor;

  logic [RW-1:0] w_div;
  logic          w_ge;
  logic [RW-1:0] w_rem_nxt;
  logic [7:0]    w_q_nxt;

  // One restoring step: trial-subtract WIDTH << k from the running remainder
  assign w_div     = DIVISOR << r_k;
  assign w_ge      = (r_rem >= w_div);
  assign w_rem_nxt = w_ge ? (r_rem - w_div) : r_rem;
  assign w_q_nxt   = w_ge ? (r_q | (8'd1 << r_k)) : r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_k     <= '0;
      r_oor   <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      posx    <= '0;
      posy    <= '0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem   <= RW'(eff);
            r_q     <= '0;
            r_k     <= 3'd7;
            r_oor   <= (RW'(eff) >= LIMIT);
            busy    <= 1'b1;
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          if (r_k == 3'd0) begin
            // Out-of-range addresses still take all 8 steps so latency is fixed
            if (r_oor) begin
              posx <= '0;
              posy <= '0;
              err  <= 1'b1;
            end else begin
              posx <= 9'(w_rem_nxt);
              posy <= {1'b0, w_q_nxt};
              err  <= 1'b0;
            end
            valid   <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k - 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
